spdif_frame_sequencer: RTL and testbench
========================================

// Module: spdif_frame_sequencer
// PURPOSE
//  Schedules the S/PDIF transmit stream between the I2S sample receiver and the biphase-mark line encoder.
//  - Accepts left/right sample pairs over a valid/ready handshake.
//  - Builds 32-slot subframes in the order preamble, audio, V, U, C, P.
//  - Sequences the 192-frame channel-status block.
//  - Flags underruns.
// PARAMETERS
//  SAMPLE_W   24            audio width; 16..24; MSB-aligned into slots 4..27, unused LSB slots = 0
//  CS_LOW     32'h0200_0004 channel-status bits 0..31 (consumer, copy ok, fs=48k); bits 32..191 = 0
// PORTS
//  pin_i2s_bclk_pll  in   1         sole clock; all logic rises on it
//  pin_user_sw       in   1         async active-low reset
//  en                in   1         sequencer enable
//  slot_tick         in   1         1-cycle pulse per S/PDIF time slot (from bit-rate divider)
//  smp_valid         in   1         sample pair offered
//  smp_left          in   SAMPLE_W  left sample, two's complement
//  smp_right         in   SAMPLE_W  right sample
//  smp_ready         out  1         holding register empty
//  slot_valid        out  1         slot outputs updated this cycle
//  slot_pre          out  2         00 none, 01 B, 10 M, 11 W
//  slot_data         out  1         slot data bit (0 during preamble slots)
//  block_start       out  1         pulses with slot 0 of frame 0
//  underrun          out  1         1-cycle pulse when a frame starts with no sample
//  err_sticky        out  1         latched underrun; cleared only by reset (drives red LED)
// BEHAVIOUR
//  Reset: all outputs 0 except smp_ready = 1; FSM = IDLE; counters 0; holding register empty.
//  Handshake:
//   - Capture on smp_valid && smp_ready; smp_ready = !hold_full.
//   - Capture and consume in the same cycle: hold_full stays 1 and holds the new pair.
//  FSM IDLE -> RUN on slot_tick && en && hold_full; frame_cnt = 0, slot = 0, subframe = L.
//  RUN: each slot_tick advances slot 0..31, then L->R, then R->L with frame_cnt+1.
//   - frame_cnt wraps 191 -> 0.
//   - Leaves RUN only at the end of an R subframe with en = 0 -> IDLE; slot_* outputs go quiet (all 0).
//  Frame start (slot_tick at L slot 0): hold moves to shift regs, hold_full <= 0.
//   - If hold is empty: send zero audio with V = 1 for both subframes, pulse underrun, set err_sticky.
//  Slot map:
//   - 0-3: preamble held on slot_pre (B if frame_cnt = 0 and L; M if L; W if R).
//   - 4-27: audio, LSB first.
//   - 28: V. 29: U = 0. 30: C = CS bit[frame_cnt], same in L and R.
//   - 31: P, even parity over slots 4..30.
//  Latency: slot_valid and slot_* registered; asserted exactly 1 cycle after the consuming slot_tick.
//  slot_tick while IDLE, or with en low in IDLE: ignored, no outputs.
//  Reset mid-frame: immediate return to reset state; the partial frame is discarded.
//  Parity accumulator clears at slot 3 of each subframe.
// STRUCTURE
//  Package spdif_pkg:
//   - preamble codes PRE_NONE/B/M/W.
//   - slot indices SLOT_AUX0 = 4, SLOT_V = 28, SLOT_U = 29, SLOT_C = 30, SLOT_P = 31.
//   - CS_BLOCK_LEN = 192.
//  Sub-module spdif_chstat_gen: frame_cnt in, C bit out (CS_LOW lookup, 0 above bit 31).
//  Top: FSM, slot/frame counters, holding register, shift regs, parity.
// TESTING
//  - Reset, en = 1, one pair L = 24'h000001, R = 24'h800000 -> first slot_pre = B; L slot 4 = 1, slots 5..27 = 0, P = 1; R preamble W, slot 27 = 1, P = 1.
//  - Continuous feed, 384 frames -> block_start at frames 0 and 192 only; C stream matches CS_LOW bits 0..31, then 0; B at frame 0 only, M elsewhere.
//  - Withhold smp_valid for one frame -> underrun pulse once, slots 4..27 = 0, V = 1 both subframes, err_sticky = 1 and stays 1.
//  - smp_valid offered the same cycle the frame start consumes hold -> no lost pair; smp_ready stays 0; next frame carries the new pair.
//  - en dropped at L slot 10 -> R subframe completes, then IDLE; no slot_valid after; re-enable restarts with B, frame_cnt = 0.
//  - Reset asserted at R slot 15 -> all outputs 0 and smp_ready = 1 immediately (async); after release, IDLE.

Source files
------------

// File: rtl/spdif_pkg.sv
// Shared S/PDIF framing constants: preamble codes, slot indices, block length.
// Latency: none (declarations only).
// Backpressure: not applicable.
package spdif_pkg;

  typedef enum logic [1:0] {
    PRE_NONE = 2'b00,
    PRE_B    = 2'b01,
    PRE_M    = 2'b10,
    PRE_W    = 2'b11
  } pre_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  // Audio field width inside a subframe (slots 4..27)
  localparam int AUD_W = 24;

  localparam logic [4:0] SLOT_AUX0     = 5'd4;
  localparam logic [4:0] SLOT_AUD_LAST = 5'd27;
  localparam logic [4:0] SLOT_V        = 5'd28;
  localparam logic [4:0] SLOT_U        = 5'd29;
  localparam logic [4:0] SLOT_C        = 5'd30;
  localparam logic [4:0] SLOT_P        = 5'd31;

  localparam int         CS_BLOCK_LEN = 192;
  localparam logic [7:0] FRAME_LAST   = 8'(CS_BLOCK_LEN - 1);
  // Only the first 32 channel-status bits can be non-zero
  localparam logic [7:0] CS_LOW_BITS  = 8'd32;

endpackage

// File: rtl/spdif_chstat_gen.sv
// Channel-status bit lookup for the current frame of the 192-frame block.
// Latency: combinational.
// Backpressure: none; pure function of frame_cnt.
module spdif_chstat_gen
  import spdif_pkg::*;
#(
  parameter logic [31:0] CS_LOW = 32'h0200_0004
) (
  input  logic [7:0] frame_cnt,
  output logic       c_bit
);

  // Bits 0..31 come from CS_LOW, everything above is zero
  always_comb begin
    c_bit = 1'b0;
    if (frame_cnt < CS_LOW_BITS) begin
      c_bit = CS_LOW[frame_cnt[4:0]];
    end
  end

endmodule

// File: rtl/spdif_frame_sequencer.sv
// Builds S/PDIF subframes slot by slot from buffered L/R sample pairs.
// Latency: slot outputs registered, valid 1 cycle after the consuming slot_tick.
// Backpressure: one-pair holding register; smp_ready low while it is full.
module spdif_frame_sequencer
  import spdif_pkg::*;
#(
  parameter int          SAMPLE_W = 24,
  parameter logic [31:0] CS_LOW   = 32'h0200_0004
) (
  input  logic                pin_i2s_bclk_pll,
  input  logic                pin_user_sw,
  input  logic                en,
  input  logic                slot_tick,
  input  logic                smp_valid,
  input  logic [SAMPLE_W-1:0] smp_left,
  input  logic [SAMPLE_W-1:0] smp_right,
  output logic                smp_ready,
  output logic                slot_valid,
  output logic [1:0]          slot_pre,
  output logic                slot_data,
  output logic                block_start,
  output logic                underrun,
  output logic                err_sticky
);

  seq_state_t          state_q, state_d;
  logic [SAMPLE_W-1:0] hold_l, hold_r;
  logic                hold_full;
  logic [AUD_W-1:0]    sh_l, sh_r;
  logic [AUD_W-1:0]    aud_l, aud_r;
  logic                v_q, par_q;
  logic [4:0]          slot_cnt;
  logic                sub_r;
  logic [7:0]          frame_cnt;
  logic [4:0]          cur_slot;
  logic                cur_r;
  logic [7:0]          cur_frame;
  logic                tick_go, frame_start, capture, c_bit, is_aud;
  pre_t                emit_pre;
  logic                emit_data;

  assign smp_ready = !hold_full;
  assign capture   = smp_valid && !hold_full;
  // Short samples sit in the MSBs of the audio field; LSB slots carry zero
  assign aud_l     = AUD_W'(hold_l) << (AUD_W - SAMPLE_W);
  assign aud_r     = AUD_W'(hold_r) << (AUD_W - SAMPLE_W);

  spdif_chstat_gen #(.CS_LOW(CS_LOW)) u_chstat (
    .frame_cnt (cur_frame),
    .c_bit     (c_bit)
  );

  // Next state plus the slot to emit; IDLE always starts at L slot 0 of frame 0
  always_comb begin
    state_d   = state_q;
    cur_slot  = slot_cnt;
    cur_r     = sub_r;
    cur_frame = frame_cnt;
    tick_go   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cur_slot  = '0;
        cur_r     = 1'b0;
        cur_frame = '0;
        if (slot_tick && en && hold_full) begin
          tick_go = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        tick_go = slot_tick;
        if (slot_tick && (slot_cnt == SLOT_P) && sub_r && !en) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    frame_start = tick_go && (cur_slot == '0) && !cur_r;
    is_aud      = (cur_slot >= SLOT_AUX0) && (cur_slot <= SLOT_AUD_LAST);

    emit_pre  = PRE_NONE;
    emit_data = 1'b0;
    if (cur_slot < SLOT_AUX0) begin
      emit_pre = cur_r ? PRE_W : ((cur_frame == '0) ? PRE_B : PRE_M);
    end else if (is_aud) begin
      emit_data = cur_r ? sh_r[0] : sh_l[0];
    end else begin
      case (cur_slot)
        SLOT_V:  emit_data = v_q;
        SLOT_U:  emit_data = 1'b0;
        SLOT_C:  emit_data = c_bit;
        SLOT_P:  emit_data = par_q;
        default: emit_data = 1'b0;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge pin_i2s_bclk_pll or negedge pin_user_sw) begin
    if (!pin_user_sw) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // Slot/subframe/frame position of the next slot; 5-bit slot wraps 31 -> 0
  always_ff @(posedge pin_i2s_bclk_pll or negedge pin_user_sw) begin
    if (!pin_user_sw) begin
      slot_cnt  <= '0;
      sub_r     <= 1'b0;
      frame_cnt <= '0;
    end else if (tick_go) begin
      slot_cnt <= cur_slot + 5'd1;
      sub_r    <= cur_r ^ (cur_slot == SLOT_P);
      if ((cur_slot == SLOT_P) && cur_r) begin
        frame_cnt <= (cur_frame == FRAME_LAST) ? 8'd0 : cur_frame + 8'd1;
      end else begin
        frame_cnt <= cur_frame;
      end
    end
  end

  // Holding register: a fresh capture wins over a same-cycle consume
  always_ff @(posedge pin_i2s_bclk_pll or negedge pin_user_sw) begin
    if (!pin_user_sw) begin
      hold_l    <= '0;
      hold_r    <= '0;
      hold_full <= 1'b0;
    end else if (capture) begin
      hold_l    <= smp_left;
      hold_r    <= smp_right;
      hold_full <= 1'b1;
    end else if (frame_start) begin
      hold_full <= 1'b0;
    end
  end

  // Audio shift registers, loaded at frame start (zeros and V=1 on underrun)
  always_ff @(posedge pin_i2s_bclk_pll or negedge pin_user_sw) begin
    if (!pin_user_sw) begin
      sh_l <= '0;
      sh_r <= '0;
      v_q  <= 1'b0;
    end else if (frame_start) begin
      sh_l <= hold_full ? aud_l : '0;
      sh_r <= hold_full ? aud_r : '0;
      v_q  <= !hold_full;
    end else if (tick_go && is_aud) begin
      if (cur_r) sh_r <= sh_r >> 1;
      else       sh_l <= sh_l >> 1;
    end
  end

  // Even parity over slots 4..30, cleared during the last preamble slot
  always_ff @(posedge pin_i2s_bclk_pll or negedge pin_user_sw) begin
    if (!pin_user_sw) begin
      par_q <= 1'b0;
    end else if (tick_go) begin
      if (cur_slot == (SLOT_AUX0 - 5'd1)) par_q <= 1'b0;
      else if ((cur_slot >= SLOT_AUX0) && (cur_slot < SLOT_P)) par_q <= par_q ^ emit_data;
    end
  end

  // Registered slot outputs; they fall quiet once the sequencer sits in IDLE
  always_ff @(posedge pin_i2s_bclk_pll or negedge pin_user_sw) begin
    if (!pin_user_sw) begin
      slot_valid  <= 1'b0;
      slot_pre    <= PRE_NONE;
      slot_data   <= 1'b0;
      block_start <= 1'b0;
      underrun    <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      slot_valid  <= tick_go;
      block_start <= frame_start && (cur_frame == '0);
      underrun    <= frame_start && !hold_full;
      err_sticky  <= err_sticky || (frame_start && !hold_full);
      if (tick_go) begin
        slot_pre  <= emit_pre;
        slot_data <= emit_data;
      end else if (state_q == ST_IDLE) begin
        slot_pre  <= PRE_NONE;
        slot_data <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spdif_frame_sequencer.sv
// Randomized bench for spdif_frame_sequencer against a frame-level reference model.
// Latency: checks slot outputs one cycle after each driven slot_tick.
// Backpressure: bench holds smp_valid until accepted by smp_ready.
module tb_spdif_frame_sequencer;

  logic        clk;
  logic        rst_n;
  logic        en, slot_tick, smp_valid;
  logic [23:0] smp_left, smp_right;
  logic        smp_ready, slot_valid, slot_data, block_start, underrun, err_sticky;
  logic [1:0]  slot_pre;

  spdif_frame_sequencer #(.SAMPLE_W(24), .CS_LOW(32'h0200_0004)) dut (
    .pin_i2s_bclk_pll (clk),
    .pin_user_sw      (rst_n),
    .en               (en),
    .slot_tick        (slot_tick),
    .smp_valid        (smp_valid),
    .smp_left         (smp_left),
    .smp_right        (smp_right),
    .smp_ready        (smp_ready),
    .slot_valid       (slot_valid),
    .slot_pre         (slot_pre),
    .slot_data        (slot_data),
    .block_start      (block_start),
    .underrun         (underrun),
    .err_sticky       (err_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [23:0] l; logic [23:0] r; } pair_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [31:0] cs_ref   = 32'h0200_0004;

  // Reference model state: accepted-but-unsent pairs and the frame position
  pair_t       q[$];
  bit          m_run = 0;
  int          m_pos = 0, m_frame = 0, m_frames_done = 0, m_ur = 0;
  bit          m_err = 0;
  bit          feed_on = 0;
  int          bs_seen = 0, ur_seen = 0;
  logic [1:0]  exp_pre [64];
  logic        exp_dat [64];
  logic [1:0]  got_pre [64];
  logic        got_dat [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected 64 slots of one frame, straight from the slot map
  task automatic build_frame(input logic [23:0] l, input logic [23:0] r, input bit v, input int frame);
    for (int s = 0; s < 2; s++) begin
      logic [23:0] smp;
      int ones;
      smp  = (s == 1) ? r : l;
      ones = 0;
      for (int k = 0; k < 32; k++) begin
        logic [1:0] p;
        logic d;
        p = 2'b00;
        d = 1'b0;
        if (k < 4)        p = (s == 1) ? 2'b11 : ((frame == 0) ? 2'b01 : 2'b10);
        else if (k <= 27) d = smp[k-4];
        else if (k == 28) d = v;
        else if (k == 30) d = (frame < 32) ? cs_ref[frame] : 1'b0;
        else if (k == 31) d = ones[0];
        if (k >= 4 && k <= 30 && d) ones++;
        exp_pre[s*32+k] = p;
        exp_dat[s*32+k] = d;
      end
    end
  endtask

  // One cycle: optional tick, model update, then check at the next falling edge
  task automatic step(input bit tick);
    bit         acc, exp_vld, exp_bs, exp_ur, chk_dat;
    logic [1:0] ep;
    logic       ed;
    int         pos;
    pair_t      np;
    exp_vld = 0; exp_bs = 0; exp_ur = 0; chk_dat = 0; ep = 2'b00; ed = 1'b0; pos = 0;
    if (feed_on && !smp_valid) begin
      smp_left  = 24'($urandom);
      smp_right = 24'($urandom);
      smp_valid = 1'b1;
    end
    acc       = smp_valid && smp_ready;
    np.l      = smp_left;
    np.r      = smp_right;
    slot_tick = tick;
    if (tick && !m_run && en && q.size() > 0) begin
      m_run = 1; m_pos = 0; m_frame = 0;
    end
    if (tick && m_run) begin
      if (m_pos == 0) begin
        if (q.size() > 0) begin
          pair_t p;
          p = q.pop_front();
          build_frame(p.l, p.r, 1'b0, m_frame);
        end else begin
          build_frame(24'h0, 24'h0, 1'b1, m_frame);
          exp_ur = 1; m_err = 1; m_ur++;
        end
        exp_bs = (m_frame == 0);
      end
      exp_vld = 1; chk_dat = 1; pos = m_pos;
      ep = exp_pre[m_pos]; ed = exp_dat[m_pos];
      m_pos++;
      if (m_pos == 64) begin
        m_pos = 0;
        m_frame = (m_frame + 1) % 192;
        m_frames_done++;
        if (!en) m_run = 0;
      end
    end else if (!m_run) begin
      chk_dat = 1;
    end
    if (acc) q.push_back(np);
    @(negedge clk);
    slot_tick = 1'b0;
    if (acc) smp_valid = 1'b0;
    chk("slot_valid", 32'(slot_valid), 32'(exp_vld));
    chk("block_start", 32'(block_start), 32'(exp_bs));
    chk("underrun", 32'(underrun), 32'(exp_ur));
    chk("err_sticky", 32'(err_sticky), 32'(m_err));
    chk("smp_ready", 32'(smp_ready), 32'(q.size() == 0));
    if (chk_dat) begin
      chk("slot_pre", 32'(slot_pre), 32'(ep));
      chk("slot_data", 32'(slot_data), 32'(ed));
    end
    if (exp_vld) begin
      got_pre[pos] = slot_pre;
      got_dat[pos] = slot_data;
    end
    if (block_start) bs_seen++;
    if (underrun) ur_seen++;
  endtask

  function automatic bit rnd_tick();
    return ($urandom_range(0, 7) != 0);
  endfunction

  initial begin
    int guard;
    int target;
    rst_n = 1'b0; en = 1'b0; slot_tick = 1'b0; smp_valid = 1'b0;
    smp_left = '0; smp_right = '0;
    repeat (2) @(negedge clk);
    chk("rst_slot_valid", 32'(slot_valid), 0);
    chk("rst_slot_pre", 32'(slot_pre), 0);
    chk("rst_slot_data", 32'(slot_data), 0);
    chk("rst_block_start", 32'(block_start), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_err_sticky", 32'(err_sticky), 0);
    chk("rst_smp_ready", 32'(smp_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed first pair: L = 1, R = 0x800000
    en = 1'b1;
    smp_left = 24'h000001; smp_right = 24'h800000; smp_valid = 1'b1;
    step(1'b0);
    feed_on = 1;
    bs_seen = 0;
    for (int i = 0; i < 64; i++) step(1'b1);
    chk("first_pre_B", 32'(got_pre[0]), 32'h1);
    chk("L_slot4", 32'(got_dat[4]), 1);
    chk("L_slot5", 32'(got_dat[5]), 0);
    chk("L_parity", 32'(got_dat[31]), 1);
    chk("R_pre_W", 32'(got_pre[32]), 32'h3);
    chk("R_slot27", 32'(got_dat[59]), 1);
    chk("R_parity", 32'(got_dat[63]), 1);

    // Continuous feed across two channel-status blocks
    guard = 0;
    while (m_frames_done < 384 && guard < 60000) begin
      step(rnd_tick());
      guard++;
    end
    chk("blocks_timeout", 32'(guard < 60000), 1);
    chk("block_start_count", bs_seen, 2);

    // Starve the holding register until one frame underruns
    feed_on = 0;
    ur_seen = 0;
    guard = 0;
    while (m_ur == 0 && guard < 2000) begin
      step(rnd_tick());
      guard++;
    end
    chk("underrun_timeout", 32'(guard < 2000), 1);
    feed_on = 1;
    target = m_frames_done + 2;
    guard = 0;
    while (m_frames_done < target && guard < 2000) begin
      step(rnd_tick());
      guard++;
    end
    chk("underrun_pulses", ur_seen, 1);
    chk("err_sticky_held", 32'(err_sticky), 1);

    // Drop enable at L slot 10; the R subframe must still complete
    guard = 0;
    while (!(m_run && m_pos == 10) && guard < 2000) begin
      step(rnd_tick());
      guard++;
    end
    en = 1'b0;
    while (m_run && guard < 4000) begin
      step(rnd_tick());
      guard++;
    end
    chk("en_drop_timeout", 32'(guard < 4000), 1);
    for (int i = 0; i < 20; i++) step(1'b1);
    en = 1'b1;
    step(1'b1);
    chk("restart_pre_B", 32'(got_pre[0]), 32'h1);
    chk("restart_block_start_seen", 32'(bs_seen > 2), 1);

    // Asynchronous reset at R slot 15
    guard = 0;
    while (!(m_run && m_pos == 48) && guard < 2000) begin
      step(1'b1);
      guard++;
    end
    chk("mid_reset_timeout", 32'(guard < 2000), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_slot_valid", 32'(slot_valid), 0);
    chk("arst_slot_pre", 32'(slot_pre), 0);
    chk("arst_slot_data", 32'(slot_data), 0);
    chk("arst_err_sticky", 32'(err_sticky), 0);
    chk("arst_smp_ready", 32'(smp_ready), 1);
    q.delete();
    m_run = 0; m_pos = 0; m_err = 0;
    feed_on = 0; smp_valid = 1'b0; slot_tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
